segre_mem_arbiter: RTL and testbench

Downstream neighbour of the instruction and data caches. Arbitrates the caches' line-granular refill reads and writeback writes onto the single main-memory port and returns the refill line plus a one-cycle completion pulse (`rcvd`) to the granted cache. Only one transaction is outstanding at a time. Writebacks and refills are serialised per client.

---
 rtl/segre_mem_arbiter_if.sv | 45 ++++
 rtl/segre_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_segre_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segre_mem_arbiter_if.sv
// Bus between the I/D caches, the memory arbiter and main memory.
// Signal names keep the arbiter's point of view (_i into the arbiter, _o out of it).
interface segre_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  localparam int LW = LINE_BYTES * 8;

  // Handshake: a cache holds *_rd_i/*_wr_i (and its address/data) as a level until its
  // *_rcvd_o pulse; the arbiter holds mem_rd_o/mem_wr_o, mem_addr_o and mem_wr_line_o
  // stable until memory answers with a one-cycle mem_ack_i.
  logic                  ic_rd_i;
  logic [ADDR_WIDTH-1:0] ic_addr_i;
  logic                  ic_rcvd_o;
  logic [LW-1:0]         ic_line_o;

  logic                  dc_rd_i;
  logic                  dc_wr_i;
  logic [ADDR_WIDTH-1:0] dc_addr_i;
  logic [ADDR_WIDTH-1:0] dc_wb_addr_i;
  logic [LW-1:0]         dc_wb_line_i;
  logic                  dc_rcvd_o;
  logic [LW-1:0]         dc_line_o;

  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [LW-1:0]         mem_wr_line_o;
  logic [LW-1:0]         mem_rd_line_i;
  logic                  mem_ack_i;

  modport slave (
    input  ic_rd_i, ic_addr_i, dc_rd_i, dc_wr_i, dc_addr_i, dc_wb_addr_i, dc_wb_line_i,
    input  mem_rd_line_i, mem_ack_i,
    output ic_rcvd_o, ic_line_o, dc_rcvd_o, dc_line_o,
    output mem_rd_o, mem_wr_o, mem_addr_o, mem_wr_line_o
  );

  modport master (
    output ic_rd_i, ic_addr_i, dc_rd_i, dc_wr_i, dc_addr_i, dc_wb_addr_i, dc_wb_line_i,
    output mem_rd_line_i, mem_ack_i,
    input  ic_rcvd_o, ic_line_o, dc_rcvd_o, dc_line_o,
    input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wr_line_o
  );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Single-outstanding line arbiter between icache/dcache and main memory.
// Define SEGRE_MEM_ARB_RR_EN for IC/DC round-robin; otherwise the dcache has fixed priority.
module segre_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  segre_mem_arbiter_if.slave    bus,
  output logic [1:0]            debug_state_o
);

  localparam int LW = LINE_BYTES * 8;
  // Clears the OFS = log2(LINE_BYTES) offset bits of a byte address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t                state_q;
  logic                  owner_dc_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         wr_line_q;
  logic                  ic_rcvd_q;
  logic                  dc_rcvd_q;
  logic [LW-1:0]         ic_line_q;
  logic [LW-1:0]         dc_line_q;

  logic                  dc_req;
  logic                  any_req;
  logic                  grant_dc;
  logic                  grant_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef SEGRE_MEM_ARB_RR_EN
  // 1 = dcache preferred on the next conflict.
  logic                  rr_ptr_q;
`endif

  always_comb begin
    dc_req  = bus.dc_rd_i | bus.dc_wr_i;
    any_req = dc_req | bus.ic_rd_i;
`ifdef SEGRE_MEM_ARB_RR_EN
    grant_dc = dc_req & (~bus.ic_rd_i | rr_ptr_q);
`else
    grant_dc = dc_req;
`endif
    // Writeback goes out before the refill that displaced it.
    grant_wr = grant_dc & bus.dc_wr_i;
    sel_addr = bus.ic_addr_i;
    if (grant_dc) begin
      sel_addr = grant_wr ? bus.dc_wb_addr_i : bus.dc_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      addr_q     <= '0;
      wr_line_q  <= '0;
      ic_rcvd_q  <= 1'b0;
      dc_rcvd_q  <= 1'b0;
      ic_line_q  <= '0;
      dc_line_q  <= '0;
`ifdef SEGRE_MEM_ARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_dc_q <= grant_dc;
            mem_rd_q   <= ~grant_wr;
            mem_wr_q   <= grant_wr;
            addr_q     <= sel_addr & ALIGN_MASK;
            if (grant_wr) begin
              wr_line_q <= bus.dc_wb_line_i;
            end
`ifdef SEGRE_MEM_ARB_RR_EN
            rr_ptr_q   <= ~grant_dc;
`endif
            state_q    <= MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          if (bus.mem_ack_i) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            // The per-client line registers double as the response register.
            if (owner_dc_q) begin
              dc_rcvd_q <= 1'b1;
              dc_line_q <= bus.mem_rd_line_i;
            end else begin
              ic_rcvd_q <= 1'b1;
              ic_line_q <= bus.mem_rd_line_i;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          ic_rcvd_q <= 1'b0;
          dc_rcvd_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_o      = mem_rd_q;
  assign bus.mem_wr_o      = mem_wr_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_wr_line_o = wr_line_q;
  assign bus.ic_rcvd_o     = ic_rcvd_q;
  assign bus.ic_line_o     = ic_line_q;
  assign bus.dc_rcvd_o     = dc_rcvd_q;
  assign bus.dc_line_o     = dc_line_q;
  assign debug_state_o     = state_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed scenarios plus randomized request mixes
// checked against an ordering model of the arbitration rules.
module tb_segre_mem_arbiter;
  localparam int AW = 32;
  localparam int LB = 16;
  localparam int LW = LB * 8;
  localparam int EW = 2 + AW + LW;  // {owner_dc, is_wr, addr, wr_line}

  logic       clk_i = 1'b0;
  logic       rsn_i;
  logic [1:0] debug_state_o;

  segre_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) bus ();

  segre_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .bus           (bus.slave),
    .debug_state_o (debug_state_o)
  );

  always #5 clk_i = ~clk_i;

  int             checks = 0;
  int             failures = 0;
  logic [EW-1:0]  exp_q[$];
  bit             served_q[$];
`ifdef SEGRE_MEM_ARB_RR_EN
  bit             model_ptr_dc;
`endif

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    return (a / LB) * LB;
  endfunction

  // Order in which a set of simultaneously raised, held requests must be served.
  function automatic void build_expected(input bit ic, input bit dcw, input bit dcr,
                                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                         input logic [AW-1:0] wa, input logic [LW-1:0] wl);
    bit pick_dc;
    while (ic || dcw || dcr) begin
`ifdef SEGRE_MEM_ARB_RR_EN
      if (ic && (dcw || dcr)) pick_dc = model_ptr_dc;
      else                    pick_dc = dcw || dcr;
      model_ptr_dc = !pick_dc;
`else
      pick_dc = dcw || dcr;
`endif
      if (pick_dc && dcw) begin
        exp_q.push_back({1'b1, 1'b1, line_base(wa), wl});
        dcw = 1'b0;
      end else if (pick_dc) begin
        exp_q.push_back({1'b1, 1'b0, line_base(da), {LW{1'b0}}});
        dcr = 1'b0;
      end else begin
        exp_q.push_back({1'b0, 1'b0, line_base(ia), {LW{1'b0}}});
        ic = 1'b0;
      end
    end
  endfunction

  task automatic clear_inputs();
    bus.ic_rd_i = 1'b0; bus.ic_addr_i = '0;
    bus.dc_rd_i = 1'b0; bus.dc_wr_i = 1'b0;
    bus.dc_addr_i = '0; bus.dc_wb_addr_i = '0; bus.dc_wb_line_i = '0;
    bus.mem_rd_line_i = '0; bus.mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1 rsn_i = 1'b1;
`ifdef SEGRE_MEM_ARB_RR_EN
    model_ptr_dc = 1'b0;
`endif
  endtask

  // Acts as memory for the next expected transaction, then as the owning cache.
  task automatic serve(input int delay, input logic [LW-1:0] rl, output bit ok);
    logic [EW-1:0] e;
    logic          e_dc, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wl, other_line;
    int            t;
    e = exp_q.pop_front();
    e_dc = e[EW-1]; e_wr = e[EW-2]; e_addr = e[LW +: AW]; e_wl = e[LW-1:0];
    ok = 1'b0;
    t = 0;
    @(negedge clk_i);
    while (!(bus.mem_rd_o || bus.mem_wr_o) && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (t >= 20) begin
      $display("FAIL mem_req_timeout: no mem_rd_o/mem_wr_o within 20 cycles, need one");
      failures++;
      return;
    end
    checks++;
    if (bus.mem_wr_o !== e_wr || bus.mem_rd_o !== !e_wr) begin
      $display("FAIL mem_type: rd=%b wr=%b, need rd=%b wr=%b", bus.mem_rd_o, bus.mem_wr_o, !e_wr, e_wr);
      failures++;
    end
    checks++;
    if (bus.mem_addr_o !== e_addr) begin
      $display("FAIL mem_addr: got %h, need %h", bus.mem_addr_o, e_addr);
      failures++;
    end
    if (e_wr) begin
      checks++;
      if (bus.mem_wr_line_o !== e_wl) begin
        $display("FAIL mem_wr_line: got %h, need %h", bus.mem_wr_line_o, e_wl);
        failures++;
      end
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.mem_wr_o !== e_wr || bus.mem_rd_o !== !e_wr || bus.mem_addr_o !== e_addr) begin
        $display("FAIL mem_hold: rd=%b wr=%b addr=%h, need rd=%b wr=%b addr=%h",
                 bus.mem_rd_o, bus.mem_wr_o, bus.mem_addr_o, !e_wr, e_wr, e_addr);
        failures++;
      end
    end
    other_line = e_dc ? bus.ic_line_o : bus.dc_line_o;
    bus.mem_rd_line_i = rl;
    bus.mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1 bus.mem_ack_i = 1'b0;
    bus.mem_rd_line_i = rand_line();
    @(negedge clk_i);
    checks++;
    if (bus.dc_rcvd_o !== e_dc || bus.ic_rcvd_o !== !e_dc) begin
      $display("FAIL rcvd_pulse: ic=%b dc=%b, need ic=%b dc=%b", bus.ic_rcvd_o, bus.dc_rcvd_o, !e_dc, e_dc);
      failures++;
    end
    checks++;
    if ((e_dc ? bus.dc_line_o : bus.ic_line_o) !== rl) begin
      $display("FAIL resp_line: got %h, need %h", e_dc ? bus.dc_line_o : bus.ic_line_o, rl);
      failures++;
    end
    checks++;
    if ((e_dc ? bus.ic_line_o : bus.dc_line_o) !== other_line) begin
      $display("FAIL other_line_hold: got %h, need %h", e_dc ? bus.ic_line_o : bus.dc_line_o, other_line);
      failures++;
    end
    checks++;
    if (bus.mem_rd_o !== 1'b0 || bus.mem_wr_o !== 1'b0) begin
      $display("FAIL mem_drop_after_ack: rd=%b wr=%b, need 0 0", bus.mem_rd_o, bus.mem_wr_o);
      failures++;
    end
    @(posedge clk_i);
    #1;
    if (e_dc && e_wr) bus.dc_wr_i = 1'b0;
    else if (e_dc)    bus.dc_rd_i = 1'b0;
    else              bus.ic_rd_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.ic_rcvd_o !== 1'b0 || bus.dc_rcvd_o !== 1'b0) begin
      $display("FAIL rcvd_one_cycle: ic=%b dc=%b, need 0 0", bus.ic_rcvd_o, bus.dc_rcvd_o);
      failures++;
    end
    served_q.push_back(e_dc);
    ok = 1'b1;
  endtask

  task automatic run_scenario(input bit ic, input bit dcw, input bit dcr,
                              input logic [AW-1:0] ia, input logic [AW-1:0] da,
                              input logic [AW-1:0] wa, input logic [LW-1:0] wl,
                              input int fixed_delay, input logic [LW-1:0] fixed_line);
    int n;
    bit ok;
    served_q.delete();
    @(posedge clk_i);
    #1;
    bus.ic_addr_i = ia; bus.dc_addr_i = da; bus.dc_wb_addr_i = wa; bus.dc_wb_line_i = wl;
    bus.ic_rd_i = ic; bus.dc_wr_i = dcw; bus.dc_rd_i = dcr;
    build_expected(ic, dcw, dcr, ia, da, wa, wl);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      serve((fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay,
            (fixed_delay < 0) ? rand_line() : fixed_line, ok);
      if (!ok) begin
        exp_q.delete();
        do_reset();
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.mem_rd_o !== 1'b0 || bus.mem_wr_o !== 1'b0 || bus.ic_rcvd_o !== 1'b0 ||
        bus.dc_rcvd_o !== 1'b0 || bus.mem_addr_o !== '0 || bus.mem_wr_line_o !== '0 ||
        bus.ic_line_o !== '0 || bus.dc_line_o !== '0 || debug_state_o !== 2'd0) begin
      $display("FAIL %s: rd=%b wr=%b icr=%b dcr=%b addr=%h state=%0d, need all outputs 0 and IDLE",
               tag, bus.mem_rd_o, bus.mem_wr_o, bus.ic_rcvd_o, bus.dc_rcvd_o, bus.mem_addr_o, debug_state_o);
      failures++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    check_all_zero("reset_values");
  endtask

  task automatic test_ic_refill();
    run_scenario(1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, '0, '0, 1, {LB{8'hA5}});
  endtask

  task automatic test_dc_wb_then_rd();
    logic [LW-1:0] wl;
    wl = rand_line();
    run_scenario(1'b0, 1'b1, 1'b1, '0, 32'h200, 32'h100, wl, -1, '0);
    checks++;
    if (served_q.size() != 2) begin
      $display("FAIL dc_two_pulses: got %0d dcache completions, need 2", served_q.size());
      failures++;
    end
  endtask

  task automatic test_simultaneous();
    bit first_dc;
`ifdef SEGRE_MEM_ARB_RR_EN
    first_dc = 1'b0;
`else
    first_dc = 1'b1;
`endif
    do_reset();
    for (int r = 0; r < 2; r++) begin
      run_scenario(1'b1, 1'b0, 1'b1, 32'h40, 32'h80, '0, '0, -1, '0);
      checks++;
      if (served_q.size() != 2 || served_q[0] !== first_dc || served_q[1] !== !first_dc) begin
        $display("FAIL simultaneous_order round %0d: first owner dc=%b of %0d, need dc=%b then dc=%b",
                 r, (served_q.size() > 0) ? served_q[0] : 1'bx, served_q.size(), first_dc, !first_dc);
        failures++;
      end
    end
  endtask

  task automatic test_latency();
    bit ok;
    served_q.delete();
    @(posedge clk_i);
    #1 bus.ic_addr_i = 32'h0000_0ABC; bus.ic_rd_i = 1'b1;
    build_expected(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, '0, '0, '0);
    @(negedge clk_i);
    checks++;
    if (bus.mem_rd_o !== 1'b0) begin
      $display("FAIL latency_not_before_sample: mem_rd_o=%b, need 0", bus.mem_rd_o);
      failures++;
    end
    // Next negedge must already show mem_rd_o; zero ack delay then gives rcvd one cycle later.
    serve(0, rand_line(), ok);
  endtask

  task automatic test_reset_mid();
    int t;
    @(posedge clk_i);
    #1 bus.ic_addr_i = 32'h0000_5550; bus.ic_rd_i = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (!bus.mem_rd_o && t < 5) begin @(negedge clk_i); t++; end
    checks++;
    if (bus.mem_rd_o !== 1'b1) begin
      $display("FAIL reset_mid_busy: mem_rd_o=%b, need 1", bus.mem_rd_o);
      failures++;
    end
    #1 rsn_i = 1'b0;
    #1 check_all_zero("reset_mid_async");
    bus.ic_rd_i = 1'b0;
    @(posedge clk_i);
    #1 rsn_i = 1'b1;
`ifdef SEGRE_MEM_ARB_RR_EN
    model_ptr_dc = 1'b0;
`endif
    @(negedge clk_i);
    bus.mem_rd_line_i = rand_line(); bus.mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1 bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.ic_rcvd_o !== 1'b0 || bus.dc_rcvd_o !== 1'b0 || bus.mem_rd_o !== 1'b0) begin
        $display("FAIL late_ack_ignored: icr=%b dcr=%b rd=%b, need 0 0 0", bus.ic_rcvd_o, bus.dc_rcvd_o, bus.mem_rd_o);
        failures++;
      end
    end
  endtask

  task automatic test_spurious_ack();
    logic [LW-1:0] icl, dcl;
    @(negedge clk_i);
    icl = bus.ic_line_o; dcl = bus.dc_line_o;
    bus.mem_rd_line_i = rand_line(); bus.mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1 bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.ic_rcvd_o !== 1'b0 || bus.dc_rcvd_o !== 1'b0 || bus.mem_rd_o !== 1'b0 ||
          bus.mem_wr_o !== 1'b0 || debug_state_o !== 2'd0 || bus.ic_line_o !== icl || bus.dc_line_o !== dcl) begin
        $display("FAIL spurious_ack: icr=%b dcr=%b rd=%b wr=%b state=%0d, need idle with lines held",
                 bus.ic_rcvd_o, bus.dc_rcvd_o, bus.mem_rd_o, bus.mem_wr_o, debug_state_o);
        failures++;
      end
    end
  endtask

  task automatic test_random();
    bit ic, dcw, dcr;
    for (int it = 0; it < 30; it++) begin
      ic = 1'($urandom()); dcw = 1'($urandom()); dcr = 1'($urandom());
      if (!(ic || dcw || dcr)) ic = 1'b1;
      run_scenario(ic, dcw, dcr, $urandom(), $urandom(), $urandom(), rand_line(), -1, '0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, need completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ic_refill();
    test_dc_wb_then_rd();
    test_simultaneous();
    test_latency();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
